ddc_nch_iq_collector: RTL and testbench

//  Parametrised N-channel I/Q output collector for the multi-channel DDC.
//  - Takes the per-channel I and Q result streams of NUM_CH single-channel DDCs.
//  - Pairs I with Q per channel and buffers each pair in a per-channel FIFO.
//  - Merges all channels into one channel-tagged ready/valid stream for the host interface.
//  - Adds runtime channel enable, backpressure and per-channel overflow and pair-error flags.

---
 rtl/ddc_nch_iq_collector.sv | 191 +++++++++++++++++++
 tb/tb_ddc_nch_iq_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ddc_nch_iq_collector.sv
// N-channel I/Q collector: pairs per-channel I/Q strobes, buffers pairs in per-channel FIFOs and
// merges them round-robin into one channel-tagged ready/valid stream.
module ddc_nch_iq_collector #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned OUTPUT_WIDTH = 24,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_CH-1:0]              Ch_Enable,
  input  logic [NUM_CH*OUTPUT_WIDTH-1:0] Data_In_I,
  input  logic [NUM_CH-1:0]              Data_In_I_Valid,
  input  logic [NUM_CH*OUTPUT_WIDTH-1:0] Data_In_Q,
  input  logic [NUM_CH-1:0]              Data_In_Q_Valid,
  output logic [OUTPUT_WIDTH-1:0]        Data_Out_I,
  output logic [OUTPUT_WIDTH-1:0]        Data_Out_Q,
  output logic [CH_W-1:0]                Data_Out_Ch,
  output logic                           Data_Out_Valid,
  input  logic                           Data_Out_Ready,
  output logic [NUM_CH-1:0]              Overflow,
  output logic [NUM_CH-1:0]              Pair_Err,
  input  logic                           Flag_Clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 2 * OUTPUT_WIDTH;
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

  // Pairing holding registers
  logic [OUTPUT_WIDTH-1:0] ih_q [NUM_CH];
  logic [OUTPUT_WIDTH-1:0] ih_d [NUM_CH];
  logic [OUTPUT_WIDTH-1:0] qh_q [NUM_CH];
  logic [OUTPUT_WIDTH-1:0] qh_d [NUM_CH];
  logic [NUM_CH-1:0]       ihv_q, ihv_d, qhv_q, qhv_d;

  // FIFO storage and pointers
  logic [PW-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0] wr_q  [NUM_CH];
  logic [AW-1:0] wr_d  [NUM_CH];
  logic [AW-1:0] rd_q  [NUM_CH];
  logic [AW-1:0] rd_d  [NUM_CH];
  logic [CW-1:0] cnt_q [NUM_CH];
  logic [CW-1:0] cnt_d [NUM_CH];
  logic [PW-1:0] wdata [NUM_CH];
  logic [NUM_CH-1:0] we, pop;

  logic [NUM_CH-1:0] ovf_q, ovf_d, perr_q, perr_d;

  // Arbiter and output register
  logic [CH_W-1:0]         ptr_q, gidx, cand;
  logic                    gnt, loadable;
  logic [OUTPUT_WIDTH-1:0] out_i_q, out_q_q;
  logic [CH_W-1:0]         out_ch_q;
  logic                    out_v_q;

  always_comb begin
    loadable = !out_v_q || Data_Out_Ready;
    gnt      = 1'b0;
    gidx     = ptr_q;
    cand     = ptr_q;
    pop      = '0;
    for (int j = 1; j <= int'(NUM_CH); j++) begin
      cand = CH_W'((int'(ptr_q) + j) % int'(NUM_CH));
      if (!gnt && Ch_Enable[cand] && (cnt_q[cand] != '0)) begin
        gnt  = 1'b1;
        gidx = cand;
      end
    end
    if (loadable && gnt) pop[gidx] = 1'b1;
  end

  always_comb begin
    ovf_d  = ovf_q & ~{NUM_CH{Flag_Clr}};
    perr_d = perr_q & ~{NUM_CH{Flag_Clr}};
    ihv_d  = ihv_q;
    qhv_d  = qhv_q;
    we     = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      logic                    i_stb, q_stb, push;
      logic [OUTPUT_WIDTH-1:0] i_in, q_in;
      i_stb    = Data_In_I_Valid[k];
      q_stb    = Data_In_Q_Valid[k];
      i_in     = Data_In_I[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      q_in     = Data_In_Q[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      ih_d[k]  = ih_q[k];
      qh_d[k]  = qh_q[k];
      wr_d[k]  = wr_q[k];
      rd_d[k]  = rd_q[k];
      cnt_d[k] = cnt_q[k];
      wdata[k] = {(i_stb ? i_in : ih_q[k]), (q_stb ? q_in : qh_q[k])};
      push     = (ihv_q[k] || i_stb) && (qhv_q[k] || q_stb);
      if (!Ch_Enable[k]) begin
        ihv_d[k] = 1'b0;
        qhv_d[k] = 1'b0;
        wr_d[k]  = '0;
        rd_d[k]  = '0;
        cnt_d[k] = '0;
      end else begin
        if (push) begin
          ihv_d[k] = 1'b0;
          qhv_d[k] = 1'b0;
        end else begin
          // A repeated strobe without its partner replaces the held sample
          if (i_stb) begin
            ih_d[k]  = i_in;
            ihv_d[k] = 1'b1;
            if (ihv_q[k]) perr_d[k] = 1'b1;
          end
          if (q_stb) begin
            qh_d[k]  = q_in;
            qhv_d[k] = 1'b1;
            if (qhv_q[k]) perr_d[k] = 1'b1;
          end
        end
        if (push) begin
          if ((cnt_q[k] == CntFull) && !pop[k]) begin
            ovf_d[k] = 1'b1;
          end else begin
            we[k]   = 1'b1;
            wr_d[k] = wr_q[k] + 1'b1;
          end
        end
        if (pop[k]) rd_d[k] = rd_q[k] + 1'b1;
        cnt_d[k] = cnt_q[k] + CW'(we[k]) - CW'(pop[k]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ihv_q  <= '0;
      qhv_q  <= '0;
      ovf_q  <= '0;
      perr_q <= '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        ih_q[k]  <= '0;
        qh_q[k]  <= '0;
        wr_q[k]  <= '0;
        rd_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      ihv_q  <= ihv_d;
      qhv_q  <= qhv_d;
      ovf_q  <= ovf_d;
      perr_q <= perr_d;
      for (int k = 0; k < int'(NUM_CH); k++) begin
        ih_q[k]  <= ih_d[k];
        qh_q[k]  <= qh_d[k];
        wr_q[k]  <= wr_d[k];
        rd_q[k]  <= rd_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (we[k]) mem_q[k][wr_q[k]] <= wdata[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_v_q  <= 1'b0;
      out_i_q  <= '0;
      out_q_q  <= '0;
      out_ch_q <= '0;
      ptr_q    <= CH_W'(NUM_CH - 1);
    end else if (loadable) begin
      if (gnt) begin
        {out_i_q, out_q_q} <= mem_q[gidx][rd_q[gidx]];
        out_ch_q <= gidx;
        out_v_q  <= 1'b1;
        ptr_q    <= gidx;
      end else begin
        out_v_q <= 1'b0;
      end
    end
  end

  assign Data_Out_I     = out_i_q;
  assign Data_Out_Q     = out_q_q;
  assign Data_Out_Ch    = out_ch_q;
  assign Data_Out_Valid = out_v_q;
  assign Overflow       = ovf_q;
  assign Pair_Err       = perr_q;

endmodule

// File: tb/tb_ddc_nch_iq_collector.sv
// Directed bench for ddc_nch_iq_collector with hand-computed expected values.
module tb_ddc_nch_iq_collector;

  localparam int NCH = 4;
  localparam int W   = 24;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NCH-1:0]   Ch_Enable;
  logic [NCH*W-1:0] Data_In_I, Data_In_Q;
  logic [NCH-1:0]   Data_In_I_Valid, Data_In_Q_Valid;
  logic [W-1:0]     Data_Out_I, Data_Out_Q;
  logic [1:0]       Data_Out_Ch;
  logic             Data_Out_Valid, Data_Out_Ready;
  logic [NCH-1:0]   Overflow, Pair_Err;
  logic             Flag_Clr;

  int n_vec = 0;
  int n_err = 0;

  ddc_nch_iq_collector #(
    .NUM_CH      (NCH),
    .OUTPUT_WIDTH(W),
    .FIFO_DEPTH  (4),
    .CH_W        (2)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Ch_Enable      (Ch_Enable),
    .Data_In_I      (Data_In_I),
    .Data_In_I_Valid(Data_In_I_Valid),
    .Data_In_Q      (Data_In_Q),
    .Data_In_Q_Valid(Data_In_Q_Valid),
    .Data_Out_I     (Data_Out_I),
    .Data_Out_Q     (Data_Out_Q),
    .Data_Out_Ch    (Data_Out_Ch),
    .Data_Out_Valid (Data_Out_Valid),
    .Data_Out_Ready (Data_Out_Ready),
    .Overflow       (Overflow),
    .Pair_Err       (Pair_Err),
    .Flag_Clr       (Flag_Clr)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_i(input int ch, input logic [W-1:0] v);
    Data_In_I[ch*W +: W] = v;
    Data_In_I_Valid[ch]  = 1'b1;
  endtask

  task automatic set_q(input int ch, input logic [W-1:0] v);
    Data_In_Q[ch*W +: W] = v;
    Data_In_Q_Valid[ch]  = 1'b1;
  endtask

  task automatic clr_stb();
    Data_In_I_Valid = '0;
    Data_In_Q_Valid = '0;
  endtask

  task automatic check_out(input string tag, input int ch, input logic [W-1:0] i,
                           input logic [W-1:0] q);
    check({tag, "_valid"}, 64'(Data_Out_Valid), 64'd1);
    check({tag, "_ch"}, 64'(Data_Out_Ch), 64'(ch));
    check({tag, "_i"}, 64'(Data_Out_I), 64'(i));
    check({tag, "_q"}, 64'(Data_Out_Q), 64'(q));
  endtask

  initial begin
    RST = 1'b1; Ch_Enable = 4'hF; Data_In_I = '0; Data_In_Q = '0;
    Data_In_I_Valid = '0; Data_In_Q_Valid = '0; Data_Out_Ready = 1'b1; Flag_Clr = 1'b0;
    tick(); tick();
    check("rst_valid", 64'(Data_Out_Valid), 64'd0);
    check("rst_i", 64'(Data_Out_I), 64'd0);
    check("rst_q", 64'(Data_Out_Q), 64'd0);
    check("rst_ch", 64'(Data_Out_Ch), 64'd0);
    check("rst_ovf", 64'(Overflow), 64'd0);
    check("rst_perr", 64'(Pair_Err), 64'd0);
    RST = 1'b0;
    tick();

    // Same-cycle pair on ch2: valid two cycles later, one cycle wide
    set_i(2, 24'h000123); set_q(2, 24'hFFFEDC);
    tick(); clr_stb();
    check("lat_n1_valid", 64'(Data_Out_Valid), 64'd0);
    tick();
    check_out("lat_n2", 2, 24'h000123, 24'hFFFEDC);
    tick();
    check("lat_n3_valid", 64'(Data_Out_Valid), 64'd0);

    // Split I/Q on ch1, three cycles apart
    set_i(1, 24'h000011);
    tick(); clr_stb();
    tick(); tick();
    set_q(1, 24'h000022);
    tick(); clr_stb();
    tick();
    check_out("split", 1, 24'h000011, 24'h000022);
    tick();
    check("split_once", 64'(Data_Out_Valid), 64'd0);
    check("split_perr", 64'(Pair_Err), 64'd0);

    // Repeated I before Q: newest I is paired, pair error is sticky
    set_i(1, 24'd5);
    tick(); clr_stb();
    tick();
    set_i(1, 24'd7);
    tick(); clr_stb();
    check("dup_perr", 64'(Pair_Err), 64'h2);
    set_q(1, 24'd9);
    tick(); clr_stb();
    tick();
    check_out("dup", 1, 24'd7, 24'd9);
    tick();
    check("dup_once", 64'(Data_Out_Valid), 64'd0);
    check("dup_perr_sticky", 64'(Pair_Err), 64'h2);
    Flag_Clr = 1'b1;
    tick(); Flag_Clr = 1'b0;
    check("dup_perr_clr", 64'(Pair_Err), 64'd0);

    // Backpressure: output reg plus full FIFO, then overflow, then ordered drain
    Data_Out_Ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      set_i(0, 24'(k)); set_q(0, 24'(256 + k));
      tick();
    end
    clr_stb();
    tick();
    check_out("bp_hold", 0, 24'd1, 24'd257);
    check("bp_no_ovf", 64'(Overflow), 64'd0);
    set_i(0, 24'd6); set_q(0, 24'd262);
    tick(); clr_stb();
    check("bp_ovf", 64'(Overflow), 64'h1);
    check_out("bp_stable", 0, 24'd1, 24'd257);
    Data_Out_Ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check_out($sformatf("drain%0d", k), 0, 24'(k), 24'(256 + k));
      tick();
    end
    check("drain_end", 64'(Data_Out_Valid), 64'd0);
    Flag_Clr = 1'b1;
    tick(); Flag_Clr = 1'b0;
    check("ovf_clr", 64'(Overflow), 64'd0);

    // Round-robin at full rate from a fresh pointer
    RST = 1'b1; tick(); RST = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      set_i(c, 24'(12'hA00 + c)); set_q(c, 24'(12'hB00 + c));
    end
    tick();
    for (int j = 0; j < 12; j++) begin
      tick();
      check_out($sformatf("rr%0d", j), j % NCH, 24'(12'hA00 + j % NCH), 24'(12'hB00 + j % NCH));
    end
    clr_stb();

    // Disabled channel never appears, then reset mid-stream
    RST = 1'b1; tick(); RST = 1'b0;
    Ch_Enable = 4'b1011;
    set_i(2, 24'h222); set_q(2, 24'h333);
    set_i(3, 24'h444); set_q(3, 24'h555);
    tick();
    for (int j = 0; j < 6; j++) begin
      tick();
      check_out($sformatf("en%0d", j), 3, 24'h444, 24'h555);
    end
    RST = 1'b1;
    tick();
    check("midrst_valid", 64'(Data_Out_Valid), 64'd0);
    check("midrst_i", 64'(Data_Out_I), 64'd0);
    check("midrst_q", 64'(Data_Out_Q), 64'd0);
    check("midrst_ch", 64'(Data_Out_Ch), 64'd0);
    RST = 1'b0;
    set_i(0, 24'h0AA); set_q(0, 24'h0BB);
    tick();
    clr_stb();
    tick();
    check_out("post_rst0", 0, 24'h0AA, 24'h0BB);
    tick();
    check_out("post_rst1", 3, 24'h444, 24'h555);
    tick();
    check("post_rst_idle", 64'(Data_Out_Valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
